tt_um_ring_freq_meter: RTL

On-die frequency meter for characterising the ring-oscillator tile: the measuring end of the oscillator output. It takes the oscillator output on a pad input, synchronises it to the system clock and counts rising edges over a programmable gate window. It then latches the count into a 16-bit result register that is read back a byte at a time on the dedicated outputs. Status flags go out on the bidirectional pins.

---
 rtl/tt_um_ring_freq_meter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tt_um_ring_freq_meter.sv
// -----------------------------------------------------------------------------
// tt_um_ring_freq_meter
//
// Frequency meter for the ring-oscillator tile. The oscillator output arrives
// on ui_in[0]. It is synchronised to clk, and its rising edges are counted
// over a programmable gate window of N system clocks. The count is latched
// into a result register, which is read back one byte at a time.
//
// Optional feature macro: FREQ_METER_CONTINUOUS_EN
//   defined   : DONE lasts one cycle and a new window starts automatically.
//   undefined : one-shot; DONE holds until the next start edge.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      design selected; low forces IDLE
//   ui_in    [0] signal under test (async), [1] start (async),
//            [3:2] gate select: 1024 / 8192 / 65536 / 262144 cycles
//   uo_out   result byte: low byte when uio_in[0]=0, high byte when 1
//   uio_in   [0] byte select
//   uio_out  [4] busy, [5] done, [6] overflow (qualified by done),
//            [7] heartbeat, [3:0] zero
//   uio_oe   constant 8'hF0
//
// Parameters:
//   GATE_W   width of the gate down-counter (>= 18)
//   CNT_W    width of the edge counter and result register (<= 16; the result
//            is zero-extended to 16 bits for readback)
// -----------------------------------------------------------------------------
module tt_um_ring_freq_meter #(
  parameter int GATE_W = 18,
  parameter int CNT_W  = 16
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  // Gate length minus one, so that the window is exactly N cycles long.
  function automatic logic [GATE_W-1:0] gate_len_m1(input logic [1:0] sel);
    case (sel)
      2'b00:   gate_len_m1 = GATE_W'(1023);
      2'b01:   gate_len_m1 = GATE_W'(8191);
      2'b10:   gate_len_m1 = GATE_W'(65535);
      default: gate_len_m1 = GATE_W'(262143);
    endcase
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != {CNT_W{1'b1}})) sat_inc = cnt + CNT_W'(1);
    else                               sat_inc = cnt;
  endfunction

  state_t              state, state_nxt;
  logic                gate_load;
  logic                sig_p0, sig_p1, sig_p2;
  logic                start_p0, start_p1, start_p2;
  logic                sig_pulse;
  logic                start_edge;
  logic [GATE_W-1:0]   gate_cnt;
  logic [CNT_W-1:0]    edge_cnt;
  logic [CNT_W-1:0]    cnt_next;
  logic [CNT_W-1:0]    result;
  logic [15:0]         result_rd;
  logic                ovf_flag;
  logic                busy;
  logic                done;
  logic [23:0]         hb_cnt;
  logic                unused;

  // Stage p0/p1: two-flop synchronisers; stage p2: delayed copy for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_p0   <= 1'b0;
      sig_p1   <= 1'b0;
      sig_p2   <= 1'b0;
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
    end else begin
      sig_p0   <= ui_in[0];
      sig_p1   <= sig_p0;
      sig_p2   <= sig_p1;
      start_p0 <= ui_in[1];
      start_p1 <= start_p0;
      start_p2 <= start_p1;
    end
  end

  assign sig_pulse  = sig_p1 & ~sig_p2;
  assign start_edge = start_p1 & ~start_p2;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    gate_load = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = GATE;
          gate_load = 1'b1;
        end
      end
      GATE: begin
        // Start edges are ignored here; the window always runs to completion.
        if (gate_cnt == '0) state_nxt = DONE;
      end
      DONE: begin
`ifdef FREQ_METER_CONTINUOUS_EN
        state_nxt = GATE;
        gate_load = 1'b1;
`else
        if (start_edge) begin
          state_nxt = GATE;
          gate_load = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
    if (!ena) begin
      state_nxt = IDLE;
      gate_load = 1'b0;
    end
  end

  assign busy     = (state == GATE);
  assign done     = (state == DONE);
  assign cnt_next = sat_inc(edge_cnt, sig_pulse);

  // Gate window: counter, overflow flag, result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
      result   <= '0;
    end else if (gate_load) begin
      gate_cnt <= gate_len_m1(ui_in[3:2]);
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (busy && ena) begin
      // The final cycle's pulse is included in the captured result.
      edge_cnt <= cnt_next;
      if (sig_pulse && (edge_cnt == {CNT_W{1'b1}})) ovf_flag <= 1'b1;
      if (gate_cnt == '0) result   <= cnt_next;
      else                gate_cnt <= gate_cnt - GATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hb_cnt <= '0;
    else        hb_cnt <= hb_cnt + 24'd1;
  end

  assign result_rd = 16'(result);
  assign uo_out    = uio_in[0] ? result_rd[15:8] : result_rd[7:0];
  assign uio_out   = {hb_cnt[23], ovf_flag & done, done, busy, 4'b0000};
  assign uio_oe    = 8'hF0;

  assign unused = &{1'b0, ui_in[7:4], uio_in[7:1]};

endmodule
